// File: rtl/code_serializer.sv
// Shifts an accepted parallel code out MSB-first on `a`, then holds IDLE_LEVEL for a guard gap.
// First bit one cycle after accept; code_ready low for CODE_WIDTH+GUARD_CYCLES cycles, valid ignored meanwhile.
module code_serializer #(
   parameter int   CODE_WIDTH   = 5,
   parameter int   GUARD_CYCLES = 2,
   parameter logic IDLE_LEVEL   = 1'b1,
   parameter int   CNT_WIDTH    = 8
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic [CODE_WIDTH-1:0] code_in,
   input  logic                  code_valid,
   output logic                  code_ready,
   output logic                  a,
   output logic                  busy,
   output logic                  frame_done,
   output logic [CNT_WIDTH-1:0]  frame_count
);

   localparam int BW = $clog2(CODE_WIDTH + 1);
   localparam int GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, GUARD} state_t;

   state_t                state;
   logic [CODE_WIDTH-1:0] shreg;
   logic [BW-1:0]         bit_cnt;
   logic [GW-1:0]         guard_cnt;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state       <= IDLE;
         a           <= IDLE_LEVEL;
         code_ready  <= 1'b1;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         frame_count <= '0;
         shreg       <= '0;
         bit_cnt     <= '0;
         guard_cnt   <= '0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (code_valid && code_ready) begin
                  // MSB goes straight to `a`; the register holds the remaining bits.
                  state      <= SHIFT;
                  a          <= code_in[CODE_WIDTH-1];
                  shreg      <= code_in << 1;
                  bit_cnt    <= BW'(1);
                  code_ready <= 1'b0;
                  busy       <= 1'b1;
               end
            end
            SHIFT: begin
               if (bit_cnt == BW'(CODE_WIDTH)) begin
                  bit_cnt <= '0;
                  a       <= IDLE_LEVEL;
                  if (GUARD_CYCLES > 0) begin
                     state     <= GUARD;
                     guard_cnt <= GW'(1);
                  end else begin
                     state       <= IDLE;
                     code_ready  <= 1'b1;
                     busy        <= 1'b0;
                     frame_done  <= 1'b1;
                     frame_count <= frame_count + CNT_WIDTH'(1);
                  end
               end else begin
                  a       <= shreg[CODE_WIDTH-1];
                  shreg   <= shreg << 1;
                  bit_cnt <= bit_cnt + BW'(1);
               end
            end
            GUARD: begin
               if (guard_cnt == GW'(GUARD_CYCLES)) begin
                  state       <= IDLE;
                  guard_cnt   <= '0;
                  code_ready  <= 1'b1;
                  busy        <= 1'b0;
                  frame_done  <= 1'b1;
                  frame_count <= frame_count + CNT_WIDTH'(1);
               end else begin
                  guard_cnt <= guard_cnt + GW'(1);
               end
            end
            default: begin
               state      <= IDLE;
               a          <= IDLE_LEVEL;
               code_ready <= 1'b1;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_code_serializer.sv
// Directed bench for code_serializer: default instance (W=5, G=2) plus a wrap instance (CNT_WIDTH=2, G=0).
module tb_code_serializer;

   logic       Clock = 1'b0;
   logic       Reset = 1'b0;
   logic [4:0] code_in = '0;
   logic       code_valid = 1'b0;
   logic       code_ready, a, busy, frame_done;
   logic [7:0] frame_count;

   logic [4:0] w_code = '0;
   logic       w_valid = 1'b0;
   logic       w_ready, w_a, w_busy, w_done;
   logic [1:0] w_count;

   int         n_checks = 0;
   int         n_pass = 0;
   logic [7:0] exp_count = '0;

   always #5 Clock = ~Clock;

   code_serializer dut (
      .Clock(Clock), .Reset(Reset), .code_in(code_in), .code_valid(code_valid),
      .code_ready(code_ready), .a(a), .busy(busy), .frame_done(frame_done),
      .frame_count(frame_count)
   );

   code_serializer #(.CODE_WIDTH(5), .GUARD_CYCLES(0), .IDLE_LEVEL(1'b1), .CNT_WIDTH(2)) u_wrap (
      .Clock(Clock), .Reset(Reset), .code_in(w_code), .code_valid(w_valid),
      .code_ready(w_ready), .a(w_a), .busy(w_busy), .frame_done(w_done),
      .frame_count(w_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Caller has valid/code set so the next rising edge accepts `code`.
   task automatic frame(input logic [4:0] code, input logic [4:0] code_after,
                        input int poke_cyc, input bit keep_valid);
      @(posedge Clock);
      for (int k = 1; k <= 8; k++) begin
         @(negedge Clock);
         if (k <= 5) begin
            chk($sformatf("bit%0d_a", k), 32'(a), 32'(code[5-k]));
            chk($sformatf("bit%0d_busy", k), 32'(busy), 32'd1);
            chk($sformatf("bit%0d_ready", k), 32'(code_ready), 32'd0);
         end else if (k <= 7) begin
            chk($sformatf("guard%0d_a", k), 32'(a), 32'd1);
            chk($sformatf("guard%0d_busy", k), 32'(busy), 32'd1);
            chk($sformatf("guard%0d_done", k), 32'(frame_done), 32'd0);
            chk($sformatf("guard%0d_count", k), 32'(frame_count), 32'(exp_count));
         end else begin
            chk("done_pulse", 32'(frame_done), 32'd1);
            chk("done_ready", 32'(code_ready), 32'd1);
            chk("done_busy", 32'(busy), 32'd0);
            chk("done_a", 32'(a), 32'd1);
            chk("done_count", 32'(frame_count), 32'(exp_count + 8'd1));
         end
         if (k == 1) begin
            code_in = code_after;
            if (!keep_valid) code_valid = 1'b0;
         end
         if (poke_cyc != 0 && k == poke_cyc) begin
            code_valid = 1'b1;
            code_in    = 5'b00000;
         end else if (poke_cyc != 0 && k == poke_cyc + 1) begin
            code_valid = 1'b0;
         end
      end
      exp_count = exp_count + 8'd1;
   endtask

   initial begin
      logic [1:0] wrap_seq [5];
      logic [4:0] wcode;
      wrap_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

      // Reset asserted between edges must act without a clock edge.
      #2 Reset = 1'b1;
      #1;
      chk("rst_a", 32'(a), 32'd1);
      chk("rst_ready", 32'(code_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(frame_done), 32'd0);
      chk("rst_count", 32'(frame_count), 32'd0);
      chk("rst_wcount", 32'(w_count), 32'd0);

      // Single frame, accepted on the first edge after reset release.
      @(negedge Clock);
      Reset      = 1'b0;
      code_in    = 5'b01011;
      code_valid = 1'b1;
      frame(5'b01011, 5'b01011, 0, 0);

      // Back-to-back with valid held; code_in changes mid-frame.
      code_in    = 5'b01011;
      code_valid = 1'b1;
      frame(5'b01011, 5'b11111, 0, 1);
      frame(5'b11111, 5'b11111, 0, 0);

      // Valid pulse during a busy frame is dropped.
      code_in    = 5'b10011;
      code_valid = 1'b1;
      frame(5'b10011, 5'b10011, 3, 0);
      @(negedge Clock);
      chk("drop_idle_busy", 32'(busy), 32'd0);
      chk("drop_count", 32'(frame_count), 32'(exp_count));

      // Abort mid-frame with an asynchronous reset.
      code_in    = 5'b01011;
      code_valid = 1'b1;
      @(posedge Clock);
      for (int k = 1; k <= 3; k++) begin
         @(negedge Clock);
         if (k == 1) code_valid = 1'b0;
      end
      chk("abort_pre_a", 32'(a), 32'd0);
      #2 Reset = 1'b1;
      #1;
      chk("abort_a", 32'(a), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_ready", 32'(code_ready), 32'd1);
      chk("abort_done", 32'(frame_done), 32'd0);
      chk("abort_count", 32'(frame_count), 32'd0);
      exp_count = '0;
      @(negedge Clock);
      chk("abort_hold_done", 32'(frame_done), 32'd0);
      @(negedge Clock);
      Reset      = 1'b0;
      code_in    = 5'b10010;
      code_valid = 1'b1;
      frame(5'b10010, 5'b10010, 0, 0);

      // Counter wrap with no guard gap: period 6, counts 1,2,3,0,1.
      wcode   = 5'b10110;
      w_code  = wcode;
      w_valid = 1'b1;
      for (int f = 0; f < 5; f++) begin
         @(posedge Clock);
         for (int k = 1; k <= 6; k++) begin
            @(negedge Clock);
            if (k <= 5) begin
               chk($sformatf("w%0d_bit%0d", f, k), 32'(w_a), 32'(wcode[5-k]));
               chk($sformatf("w%0d_done%0d", f, k), 32'(w_done), 32'd0);
            end else begin
               chk($sformatf("w%0d_idle_a", f), 32'(w_a), 32'd1);
               chk($sformatf("w%0d_done", f), 32'(w_done), 32'd1);
               chk($sformatf("w%0d_count", f), 32'(w_count), 32'(wrap_seq[f]));
            end
            if (f == 4 && k == 1) w_valid = 1'b0;
         end
      end
      @(negedge Clock);
      chk("w_final_busy", 32'(w_busy), 32'd0);
      chk("w_final_ready", 32'(w_ready), 32'd1);
      chk("main_untouched", 32'(frame_count), 32'(exp_count));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
